lc3_dmem_responder: RTL and testbench

Synthesizable data-memory responder for the LC3 bench: the memory end of the LC3 data-memory interface (`Data_addr`/`Data_din`/`Data_rd` in, `Data_dout`/`complete_data` out). It owns the word storage and answers one outstanding read or write with a fixed, parameterized latency. It gives the LC3 top a real memory instead of a tied-high `complete_data`. It runs alongside the passive `dmem_agent` monitor, which observes the same signals.

---
 rtl/lc3_dmem_pkg.sv | 13 +
 rtl/lc3_dmem_array.sv | 26 ++
 rtl/lc3_dmem_responder.sv | 137 +++++++++++++
 tb/tb_lc3_dmem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_dmem_pkg.sv
// rtl/lc3_dmem_pkg.sv - shared types and constants for the LC3 data-memory responder
package lc3_dmem_pkg;

    localparam int LC3_WORD_W           = 16;
    localparam int LC3_DMEM_MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/lc3_dmem_array.sv
// rtl/lc3_dmem_array.sv - single-port word storage, synchronous write, combinational read
module lc3_dmem_array
    import lc3_dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     idx_i,
    input  logic [LC3_WORD_W-1:0] wdata_i,
    output logic [LC3_WORD_W-1:0] rdata_o
);

    // Storage is deliberately not reset so its contents survive a system reset.
    logic [LC3_WORD_W-1:0] mem_q [2**ADDR_W];

    // Commit a word on the clock edge when write enable is high.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/lc3_dmem_responder.sv
// rtl/lc3_dmem_responder.sv - fixed-latency LC3 data-memory responder (optional counters: LC3_DMEM_ACCESS_CNT_EN)
module lc3_dmem_responder
    import lc3_dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Data_en,
    input  logic                  Data_rd,
    input  logic [15:0]           Data_addr,
    input  logic [LC3_WORD_W-1:0] Data_din,
    output logic [LC3_WORD_W-1:0] Data_dout,
    output logic                  complete_data
`ifdef LC3_DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
`endif
);

    if (LATENCY < 1 || LATENCY > LC3_DMEM_MAX_LATENCY) begin : g_bad_latency
        $error("lc3_dmem_responder: LATENCY must be within 1..15");
    end

    // Countdown start value; BUSY lasts LATENCY-1 cycles ending at zero.
    localparam logic [3:0] INIT_WAIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_e           state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic                  rd_q, rd_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [LC3_WORD_W-1:0] din_q, din_d;
    logic [LC3_WORD_W-1:0] dout_q, dout_d;
    logic [LC3_WORD_W-1:0] arr_rdata;
    logic                  go_done;
    logic                  arr_we;

    // Upper address bits alias onto the array and are intentionally dropped.
    if (ADDR_W < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^Data_addr[15:ADDR_W];
    end

    // Next-state, capture and completion-side effects; the _d capture values
    // already hold the live inputs on an accepting edge, so LATENCY=1 works.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        din_d   = din_q;
        case (state_q)
            IDLE, DONE: begin
                if (Data_en) begin
                    rd_d  = Data_rd;
                    idx_d = Data_addr[ADDR_W-1:0];
                    din_d = Data_din;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        wait_d  = INIT_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (wait_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        go_done = (state_d == DONE);
        arr_we  = go_done && !rd_d && !reset;
        dout_d  = (go_done && rd_d) ? arr_rdata : dout_q;
    end

    lc3_dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clock),
        .we_i    (arr_we),
        .idx_i   (idx_d),
        .wdata_i (din_d),
        .rdata_o (arr_rdata)
    );

    // State, countdown and capture registers; reset aborts any transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            din_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
        end
    end

    assign complete_data = (state_q == DONE);
    assign Data_dout     = dout_q;

`ifdef LC3_DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    // Count each completed access by type; 16-bit counters wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (state_q == DONE) begin
            if (rd_q) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end else begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// tb/tb_lc3_dmem_responder.sv - self-checking bench for lc3_dmem_responder at LATENCY 1, 2 and 4
module tb_lc3_dmem_responder;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        en   [3];
    logic        rd   [3];
    logic [15:0] addr [3];
    logic [15:0] din  [3];
    logic [15:0] dout [3];
    logic        cd   [3];
`ifdef LC3_DMEM_ACCESS_CNT_EN
    logic [15:0] rdc  [3];
    logic [15:0] wrc  [3];
`endif

    always #5 clk = ~clk;

    lc3_dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
        .clock(clk), .reset(rst[0]), .Data_en(en[0]), .Data_rd(rd[0]),
        .Data_addr(addr[0]), .Data_din(din[0]), .Data_dout(dout[0]),
        .complete_data(cd[0])
`ifdef LC3_DMEM_ACCESS_CNT_EN
        , .rd_cnt(rdc[0]), .wr_cnt(wrc[0])
`endif
    );

    lc3_dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
        .clock(clk), .reset(rst[1]), .Data_en(en[1]), .Data_rd(rd[1]),
        .Data_addr(addr[1]), .Data_din(din[1]), .Data_dout(dout[1]),
        .complete_data(cd[1])
`ifdef LC3_DMEM_ACCESS_CNT_EN
        , .rd_cnt(rdc[1]), .wr_cnt(wrc[1])
`endif
    );

    lc3_dmem_responder #(.ADDR_W(8), .LATENCY(4)) u_l4 (
        .clock(clk), .reset(rst[2]), .Data_en(en[2]), .Data_rd(rd[2]),
        .Data_addr(addr[2]), .Data_din(din[2]), .Data_dout(dout[2]),
        .complete_data(cd[2])
`ifdef LC3_DMEM_ACCESS_CNT_EN
        , .rd_cnt(rdc[2]), .wr_cnt(wrc[2])
`endif
    );

    // Reference model: word memory indexed by low 8 address bits, last read value, access counts.
    logic [15:0] mem_m   [3][256];
    bit          valid_m [3][256];
    logic [15:0] dout_m  [3];
    logic [15:0] rdn_m   [3];
    logic [15:0] wrn_m   [3];

    int vectors    = 0;
    int miscompares = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input int k);
`ifdef LC3_DMEM_ACCESS_CNT_EN
        chk($sformatf("rd_cnt[%0d]", k), rdc[k], rdn_m[k]);
        chk($sformatf("wr_cnt[%0d]", k), wrc[k], wrn_m[k]);
`endif
    endtask

    task automatic model_reset(input int k);
        dout_m[k] = 16'h0000;
        rdn_m[k]  = 16'h0000;
        wrn_m[k]  = 16'h0000;
    endtask

    // One isolated access: request for one cycle, inputs scrambled afterwards.
    task automatic access(input int k, input bit r, input logic [15:0] a, input logic [15:0] d);
        int n;
        @(negedge clk);
        en[k] = 1'b1; rd[k] = r; addr[k] = a; din[k] = d;
        @(posedge clk);
        @(negedge clk);
        en[k] = 1'b0; rd[k] = 1'($urandom); addr[k] = 16'($urandom); din[k] = 16'($urandom);
        n = 1;
        while (cd[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency[%0d]", k), n, lat_of(k));
        if (r) begin
            dout_m[k] = mem_m[k][a[7:0]];
            rdn_m[k]  = rdn_m[k] + 16'd1;
        end else begin
            mem_m[k][a[7:0]]   = d;
            valid_m[k][a[7:0]] = 1'b1;
            wrn_m[k]           = wrn_m[k] + 16'd1;
        end
        chk($sformatf("dout[%0d]", k), dout[k], dout_m[k]);
        @(negedge clk);
        chk($sformatf("pulse_width[%0d]", k), cd[k], 1'b0);
        chk_counters(k);
    endtask

    initial begin
        int completions;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; en[k] = 1'b0; rd[k] = 1'b0; addr[k] = '0; din[k] = '0;
            model_reset(k);
            for (int i = 0; i < 256; i++) valid_m[k][i] = 1'b0;
        end

        // Reset for two cycles, then check reset state on every instance.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_cd[%0d]", k), cd[k], 1'b0);
            chk($sformatf("reset_dout[%0d]", k), dout[k], 16'h0000);
            chk_counters(k);
        end

        // Write then read at LATENCY=2.
        access(1, 1'b0, 16'h0010, 16'hBEEF);
        access(1, 1'b1, 16'h0010, 16'h0000);
        chk("beef_readback", dout[1], 16'hBEEF);

        // Back-to-back write then read at LATENCY=1 with Data_en held in DONE.
        @(negedge clk);
        en[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0005; din[0] = 16'h1234;
        @(negedge clk);
        chk("b2b_write_cd", cd[0], 1'b1);
        mem_m[0][5] = 16'h1234; valid_m[0][5] = 1'b1; wrn_m[0] = wrn_m[0] + 16'd1;
        rd[0] = 1'b1; din[0] = 16'h0000;
        @(negedge clk);
        en[0] = 1'b0;
        chk("b2b_read_cd", cd[0], 1'b1);
        chk("b2b_read_dout", dout[0], 16'h1234);
        dout_m[0] = 16'h1234; rdn_m[0] = rdn_m[0] + 16'd1;
        @(negedge clk);
        chk("b2b_idle_cd", cd[0], 1'b0);
        chk_counters(0);

        // Aliasing: upper address bits ignored.
        access(1, 1'b0, 16'h0103, 16'hA5A5);
        access(1, 1'b1, 16'h0003, 16'h0000);
        chk("alias_readback", dout[1], 16'hA5A5);

        // Data_en pulses during BUSY must be ignored (LATENCY=4).
        access(2, 1'b0, 16'h0041, 16'h7777);
        @(negedge clk);
        en[2] = 1'b1; rd[2] = 1'b0; addr[2] = 16'h0040; din[2] = 16'h1111;
        @(negedge clk);
        addr[2] = 16'h0041; din[2] = 16'h9999;
        completions = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) en[2] = 1'b0;
            if (cd[2] === 1'b1) completions++;
            @(negedge clk);
        end
        chk("busy_ignore_completions", completions, 1);
        mem_m[2][8'h40] = 16'h1111; valid_m[2][8'h40] = 1'b1; wrn_m[2] = wrn_m[2] + 16'd1;
        access(2, 1'b1, 16'h0041, 16'h0000);
        access(2, 1'b1, 16'h0040, 16'h0000);

        // Reset mid-write (LATENCY=4), with Data_en asserted alongside reset.
        access(2, 1'b0, 16'h0020, 16'h2222);
        @(negedge clk);
        en[2] = 1'b1; rd[2] = 1'b0; addr[2] = 16'h0020; din[2] = 16'hFFFF;
        completions = 0;
        @(negedge clk);
        en[2] = 1'b0;
        if (cd[2] === 1'b1) completions++;
        @(negedge clk);
        if (cd[2] === 1'b1) completions++;
        rst[2] = 1'b1; en[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (cd[2] === 1'b1) completions++;
        end
        rst[2] = 1'b0; en[2] = 1'b0;
        model_reset(2);
        chk("midreset_dout", dout[2], 16'h0000);
        chk_counters(2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cd[2] === 1'b1) completions++;
        end
        chk("midreset_completions", completions, 0);
        access(2, 1'b1, 16'h0020, 16'h0000);
        chk("midreset_prior_value", dout[2], 16'h2222);

        // Randomized accesses against the model; reads only hit written words.
        for (int i = 0; i < 150; i++) begin
            int          k;
            bit          r;
            logic [7:0]  idx;
            logic [15:0] a;
            k   = int'($urandom_range(0, 2));
            idx = 8'($urandom_range(0, 255));
            r   = 1'($urandom) && valid_m[k][idx];
            a   = {8'($urandom), idx};
            access(k, r, a, 16'($urandom));
        end

`ifdef LC3_DMEM_ACCESS_CNT_EN
        // 65,536 back-to-back reads wrap rd_cnt back to its start; wr_cnt untouched.
        @(negedge clk);
        en[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'h0005;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        dout_m[0] = mem_m[0][5];
        chk("wrap_dout", dout[0], dout_m[0]);
        chk_counters(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
